// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module  : bram_stream_reader
// Brief   : Reads a block of words from a BRAM port and replays it as a
//           valid/ready stream with tlast. BRAM_STREAM_READER_LOOP_EN adds a
//           loop input for repeated passes over the same block.
// Rev     : 1.0  initial release
// ============================================================================
module bram_stream_reader #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
`ifdef BRAM_STREAM_READER_LOOP_EN
    input  logic                loop,
`endif
    input  logic [ADDR_W-3:0]   base_word,
    input  logic [ADDR_W-2:0]   length,
    output logic                busy,
    output logic                done,
    output logic                bram_clk,
    output logic                bram_rst,
    output logic                bram_en,
    output logic [DATA_W/8-1:0] bram_we,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [DATA_W-1:0]   bram_din,
    input  logic [DATA_W-1:0]   bram_dout,
    output logic [DATA_W-1:0]   m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_SUM_W = c_CNT_W + 1;
    localparam logic [c_SUM_W-1:0] c_DEPTH = c_SUM_W'(FIFO_DEPTH);

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_ISSUE = 2'd1;
    localparam state_t c_ST_DRAIN = 2'd2;
    localparam state_t c_ST_FIN   = 2'd3;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-3:0]     r_base;
    logic [ADDR_W-3:0]     r_addr;
    logic [ADDR_W-2:0]     r_len;
    logic [ADDR_W-2:0]     r_remain;
    logic [RD_LAT-1:0]     r_pipe_v;
    logic [RD_LAT-1:0]     r_pipe_l;
    logic [DATA_W-1:0]     r_mem_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_mem_l;
    logic [c_CNT_W-1:0]    r_wr_ptr;
    logic [c_CNT_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    w_count;
    logic [c_SUM_W-1:0]    w_inflight;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_loop;
    logic                  w_accept_start;
    logic                  w_credit_ok;
    logic                  w_issue;
    logic                  w_last_issue;
    logic                  w_abort;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_final;

`ifdef BRAM_STREAM_READER_LOOP_EN
    assign w_loop = loop;
`else
    assign w_loop = 1'b0;
`endif

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + c_SUM_W'(r_pipe_v[i]);
        end
    end

    // Reads in flight plus buffered words never exceed the FIFO depth, so a
    // returning read always has a slot regardless of m_tready.
    assign w_count        = r_wr_ptr - r_rd_ptr;
    assign w_credit_ok    = (c_SUM_W'(w_count) + w_inflight) < c_DEPTH;
    assign w_accept_start = (r_state == c_ST_IDLE) && start && !abort;
    assign w_issue        = (r_state == c_ST_ISSUE) && w_credit_ok;
    assign w_last_issue   = w_issue && (r_remain == (ADDR_W-1)'(1));
    assign w_abort        = abort && ((r_state == c_ST_ISSUE) || (r_state == c_ST_DRAIN));
    assign w_push         = r_pipe_v[RD_LAT-1];
    assign w_pop          = m_tvalid && m_tready;
    // Completion needs the very last word leaving with nothing else behind it;
    // an earlier pass's tlast can still be queued when looping.
    assign w_final        = w_pop && m_tlast && (w_inflight == '0) && (w_count == c_CNT_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept_start) begin
                    w_state_nxt = (length == '0) ? c_ST_FIN : c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                if (abort) begin
                    w_state_nxt = c_ST_FIN;
                end else if (w_last_issue && !w_loop) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (abort || w_final) begin
                    w_state_nxt = c_ST_FIN;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_base   <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_remain <= '0;
            r_pipe_v <= '0;
            r_pipe_l <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != c_ST_IDLE);
            r_done  <= (r_state == c_ST_FIN);

            if (w_accept_start) begin
                r_base   <= base_word;
                r_len    <= length;
                r_addr   <= base_word;
                r_remain <= length;
            end else if (w_issue) begin
                if (w_last_issue && w_loop) begin
                    r_addr   <= r_base;
                    r_remain <= r_len;
                end else begin
                    r_addr   <= r_addr + (ADDR_W-2)'(1);
                    r_remain <= r_remain - (ADDR_W-1)'(1);
                end
            end

            if (w_abort) begin
                r_pipe_v <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                r_pipe_v[0] <= w_issue;
                r_pipe_l[0] <= w_last_issue;
                for (int i = 1; i < RD_LAT; i++) begin
                    r_pipe_v[i] <= r_pipe_v[i-1];
                    r_pipe_l[i] <= r_pipe_l[i-1];
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_CNT_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_d[r_wr_ptr[c_PTR_W-1:0]] <= bram_dout;
            r_mem_l[r_wr_ptr[c_PTR_W-1:0]] <= r_pipe_l[RD_LAT-1];
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign bram_clk  = clk;
    assign bram_rst  = reset;
    assign bram_en   = w_issue;
    assign bram_we   = '0;
    assign bram_addr = {r_addr, 2'b00};
    assign bram_din  = '0;
    assign m_tvalid  = (w_count != '0);
    assign m_tdata   = m_tvalid ? r_mem_d[r_rd_ptr[c_PTR_W-1:0]] : '0;
    assign m_tlast   = m_tvalid && r_mem_l[r_rd_ptr[c_PTR_W-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_bram_stream_reader
// Brief   : Self-checking bench for bram_stream_reader with a BRAM model and a
//           word-queue reference of the expected stream.
// Rev     : 1.0  initial release
// ============================================================================
module tb_bram_stream_reader;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 32;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int NWORDS     = 1 << (ADDR_W - 2);

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                abort;
`ifdef BRAM_STREAM_READER_LOOP_EN
    logic                loop;
`endif
    logic [ADDR_W-3:0]   base_word;
    logic [ADDR_W-2:0]   length;
    logic                busy;
    logic                done;
    logic                bram_clk;
    logic                bram_rst;
    logic                bram_en;
    logic [DATA_W/8-1:0] bram_we;
    logic [ADDR_W-1:0]   bram_addr;
    logic [DATA_W-1:0]   bram_din;
    logic [DATA_W-1:0]   bram_dout;
    logic [DATA_W-1:0]   m_tdata;
    logic                m_tvalid;
    logic                m_tready;
    logic                m_tlast;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem [NWORDS];
    logic [DATA_W-1:0] rd_q1;
    logic [DATA_W-1:0] rd_q2;

    bram_stream_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
`ifdef BRAM_STREAM_READER_LOOP_EN
        .loop      (loop),
`endif
        .base_word (base_word),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .bram_clk  (bram_clk),
        .bram_rst  (bram_rst),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast)
    );

    always #5 clk = ~clk;

    // Two-cycle read BRAM: address register then output register.
    always @(posedge clk) begin
        if (bram_en) rd_q1 <= mem[bram_addr[ADDR_W-1:2]];
        rd_q2 <= rd_q1;
    end
    assign bram_dout = rd_q2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transfer; the expected stream is the block of words repeated per pass.
    task automatic run_xfer(input int base, input int len, input int passes, input int rdy_pct,
                            input int stop_at, input bit by_reset);
        logic [DATA_W-1:0] exp_q[$];
        logic [DATA_W-1:0] exp_w;
        logic [DATA_W-1:0] prev_data;
        logic              prev_last;
        bit                prev_stall, stop_pending, stopped, timed_out;
        int                issued, accepted, done_cnt, done_k, stop_k, budget, total, exp_addr;
        total = len * passes;
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < len; i++) exp_q.push_back(mem[(base + i) % NWORDS]);
        issued = 0; accepted = 0; done_cnt = 0; done_k = -1; stop_k = -1;
        prev_stall = 0; stop_pending = 0; stopped = 0; timed_out = 1;
        prev_data = '0; prev_last = 1'b0;
        budget = 40 * total + 60;
        base_word = (ADDR_W-2)'(base);
        length    = (ADDR_W-1)'(len);
        m_tready  = 1'b0;
        start     = 1'b1;
        step();
        for (int k = 1; k <= budget; k++) begin
            // Inputs are sampled only at the accepted start; scramble them now.
            base_word = (ADDR_W-2)'($urandom);
            length    = (ADDR_W-1)'($urandom);
            start     = (k == 2 && len >= 4);
            if (stop_pending) begin
                abort = 1'b0; reset = 1'b0; stop_pending = 0; stopped = 1; stop_k = k;
                chk("stop_tvalid", 64'(m_tvalid), 64'(0));
                chk("stop_en", 64'(bram_en), 64'(0));
                if (by_reset) begin
                    chk("rst_busy", 64'(busy), 64'(0));
                    chk("rst_done", 64'(done), 64'(0));
                    chk("rst_addr", 64'(bram_addr), 64'(0));
                    chk("rst_tlast", 64'(m_tlast), 64'(0));
                    chk("rst_tdata", 64'(m_tdata), 64'(0));
                    timed_out = 0;
                    break;
                end
            end
`ifdef BRAM_STREAM_READER_LOOP_EN
            loop = (len > 0) && ((issued / len) < passes - 1);
`endif
            if (bram_en) begin
                if (len == 0 || issued >= total) begin
                    chk("en_extra", 64'(bram_en), 64'(0));
                end else begin
                    exp_addr = ((base + (issued % len)) % NWORDS) * 4;
                    chk("addr", 64'(bram_addr), 64'(exp_addr));
                end
                issued++;
            end
            if (!stopped) chk("credit", 64'((issued - accepted) <= FIFO_DEPTH), 64'(1));
            if (prev_stall) begin
                chk("hold_valid", 64'(m_tvalid), 64'(1));
                chk("hold_data", 64'(m_tdata), 64'(prev_data));
                chk("hold_last", 64'(m_tlast), 64'(prev_last));
            end
            if (!m_tvalid) chk("tlast_idle", 64'(m_tlast), 64'(0));
            m_tready = ($urandom_range(99) < rdy_pct);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 64'(m_tvalid), 64'(0));
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("data", 64'(m_tdata), 64'(exp_w));
                    chk("last", 64'(m_tlast), 64'((accepted % len) == len - 1));
                    if (rdy_pct == 100) chk("latency", 64'(k), 64'(RD_LAT + 2 + accepted));
                end
                accepted++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            if (done_k < 0) chk("busy", 64'(busy), 64'(!done));
            else chk("busy_after", 64'(busy), 64'(0));
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (stop_at >= 0 && !stopped && !stop_pending && accepted == stop_at) begin
                if (by_reset) reset = 1'b1;
                else abort = 1'b1;
                stop_pending = 1;
                prev_stall   = 0;
            end
            if (done_k >= 0 && k >= done_k + 3) begin
                timed_out = 0;
                break;
            end
            step();
        end
        m_tready = 1'b0;
        start    = 1'b0;
`ifdef BRAM_STREAM_READER_LOOP_EN
        loop     = 1'b0;
`endif
        chk("timeout", 64'(timed_out), 64'(0));
        chk("done_count", 64'(done_cnt), 64'(by_reset ? 0 : 1));
        if (stop_at < 0) begin
            chk("words_left", 64'(exp_q.size()), 64'(0));
            chk("issued", 64'(issued), 64'(total));
            if (len == 0) chk("zero_done_k", 64'(done_k), 64'(2));
        end else if (!by_reset) begin
            chk("abort_done_k", 64'(done_k), 64'(stop_k + 1));
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000 + i;
        reset = 1'b1; start = 1'b0; abort = 1'b0; m_tready = 1'b0;
        base_word = '0; length = '0;
`ifdef BRAM_STREAM_READER_LOOP_EN
        loop = 1'b0;
`endif
        step(); step();
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_en", 64'(bram_en), 64'(0));
        chk("reset_addr", 64'(bram_addr), 64'(0));
        chk("reset_tvalid", 64'(m_tvalid), 64'(0));
        chk("reset_tlast", 64'(m_tlast), 64'(0));
        chk("reset_tdata", 64'(m_tdata), 64'(0));
        chk("bram_rst_hi", 64'(bram_rst), 64'(1));
        chk("bram_clk", 64'(bram_clk), 64'(clk));
        chk("bram_we", 64'(bram_we), 64'(0));
        chk("bram_din", 64'(bram_din), 64'(0));
        reset = 1'b0;
        step();
        chk("bram_rst_lo", 64'(bram_rst), 64'(0));

        // Abort alone in idle, then start together with abort: nothing starts.
        abort = 1'b1; step(); abort = 1'b0;
        chk("idle_abort_busy", 64'(busy), 64'(0));
        step();
        chk("idle_abort_done", 64'(done), 64'(0));
        base_word = '0; length = (ADDR_W-1)'(8);
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("start_abort_busy", 64'(busy), 64'(0));
            chk("start_abort_en", 64'(bram_en), 64'(0));
            chk("start_abort_done", 64'(done), 64'(0));
            step();
        end

        run_xfer(0, 16, 1, 100, -1, 0);
        run_xfer(5, 0, 1, 100, -1, 0);
        run_xfer(int'($urandom_range(NWORDS - 1)), 64, 1, 30, -1, 0);
        run_xfer(NWORDS - 2, 4, 1, 100, -1, 0);
        run_xfer(100, 1000, 1, 100, 10, 0);
        run_xfer(0, 2, 1, 100, -1, 0);
        run_xfer(200, 1000, 1, 100, 10, 1);
        run_xfer(0, 2, 1, 100, -1, 0);
        for (int t = 0; t < 4; t++)
            run_xfer(int'($urandom_range(NWORDS - 1)), int'($urandom_range(1, 40)), 1,
                     int'($urandom_range(20, 100)), -1, 0);
`ifdef BRAM_STREAM_READER_LOOP_EN
        run_xfer(10, 3, 3, 100, -1, 0);
        run_xfer(NWORDS - 1, 2, 2, 40, -1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
